bcd2bin_seq: RTL and testbench

Sequential BCD-to-binary converter: the decode direction of the display path's binary-to-BCD stage. Accepts a packed NDIG-digit BCD word on a start strobe and converts it with a reverse double-dabble (shift-right, subtract-3) loop, one bit per clock. It returns the binary value with a one-cycle done pulse. Sits between BCD sources (thumbwheel/keypad entry, BCD counters) and binary datapath logic.

---
 rtl/bcd_pkg.sv | 25 ++
 rtl/bcd_digit_adj.sv | 13 +
 rtl/bcd2bin_seq.sv | 109 ++++++++++
 tb/tb_bcd2bin_seq.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD definitions for the display-path binary<->BCD converters.
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;
  localparam int BCD_MAX     = 9;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } bcd_state_e;

  // Ceiling log2, usable in constant expressions for counter widths.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD digit correction cell for reverse double-dabble: after a right
// shift a digit >= 8 carries a half-ten from above, so subtract 3 to make it
// a proper halved decimal digit again.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] nib,
  output logic [BCD_DIGIT_W-1:0] adj
);

  assign adj = (nib >= 4'd8) ? (nib - 4'd3) : nib;

endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter. Reverse double-dabble: the BCD word is
// shifted right one bit per clock into a binary accumulator, with each BCD
// digit corrected after every shift. Invalid digits short-circuit to an
// error completion without entering the shift loop.
module bcd2bin_seq
  import bcd_pkg::*;
#(
  parameter int NDIG  = 3,
  parameter int BIN_W = 10
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [BCD_DIGIT_W*NDIG-1:0] bcd_in,
  output logic                        busy,
  output logic                        done,
  output logic [BIN_W-1:0]            bin_out,
  output logic                        err
);

  localparam int SR_W  = BCD_DIGIT_W * NDIG;
  localparam int CNT_W = (clog2(SR_W) > 0) ? clog2(SR_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SR_W - 1);

  bcd_state_e        state;
  logic [SR_W-1:0]   bcd_reg;
  logic [SR_W-1:0]   acc;
  logic [CNT_W-1:0]  cnt;

  logic [SR_W-1:0]   bcd_shift;
  logic [SR_W-1:0]   bcd_adj;
  logic [SR_W-1:0]   acc_shift;
  logic              acc_lsb_unused;

  // True when any digit of the packed word lies outside 0..9.
  function automatic logic has_bad_digit(input logic [SR_W-1:0] w);
    for (int i = 0; i < NDIG; i++) begin
      if (w[i*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_DIGIT_W'(BCD_MAX))
        return 1'b1;
    end
    return 1'b0;
  endfunction

  // The {bcd_reg, acc} pair shifts right as one word; the accumulator LSB
  // simply falls off the end each step.
  assign bcd_shift      = bcd_reg >> 1;
  assign acc_shift      = {bcd_reg[0], acc[SR_W-1:1]};
  assign acc_lsb_unused = acc[0];

  // Per-digit correction applied to the freshly shifted BCD register.
  for (genvar g = 0; g < NDIG; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .nib (bcd_shift[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .adj (bcd_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Control FSM, shift datapath and result registers. After SR_W shifts the
  // binary value sits right-aligned in acc; its high bits are zero for any
  // valid BCD word, so the low BIN_W bits are the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      bin_out <= '0;
      err     <= 1'b0;
      bcd_reg <= '0;
      acc     <= '0;
      cnt     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (has_bad_digit(bcd_in)) begin
              done    <= 1'b1;
              err     <= 1'b1;
              bin_out <= '0;
            end else begin
              bcd_reg <= bcd_in;
              acc     <= '0;
              cnt     <= '0;
              err     <= 1'b0;
              busy    <= 1'b1;
              state   <= SHIFT;
            end
          end
        end
        SHIFT: begin
          bcd_reg <= bcd_adj;
          acc     <= acc_shift;
          cnt     <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            bin_out <= acc_shift[BIN_W-1:0];
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Directed bench for bcd2bin_seq (NDIG=3, BIN_W=10).
module tb_bcd2bin_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [11:0] bcd_in;
  logic        busy;
  logic        done;
  logic [9:0]  bin_out;
  logic        err;

  int n_checks;
  int n_errors;

  bcd2bin_seq #(.NDIG(3), .BIN_W(10)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bcd_in  (bcd_in),
    .busy    (busy),
    .done    (done),
    .bin_out (bin_out),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One valid conversion: start for a single cycle, busy for 12 cycles,
  // then a done pulse carrying exp, then the result holds.
  task automatic convert(input logic [11:0] bcd, input int exp, input string tag);
    start  = 1'b1;
    bcd_in = bcd;
    tick();
    start  = 1'b0;
    bcd_in = 12'hFFF;
    chk({tag, "_busy0"}, 32'(busy), 1);
    for (int i = 1; i < 12; i++) begin
      tick();
      chk({tag, "_busy"}, 32'(busy), 1);
      chk({tag, "_nodone"}, 32'(done), 0);
    end
    tick();
    chk({tag, "_done"}, 32'(done), 1);
    chk({tag, "_busyfall"}, 32'(busy), 0);
    chk({tag, "_bin"}, 32'(bin_out), 32'(exp));
    chk({tag, "_err"}, 32'(err), 0);
    tick();
    chk({tag, "_donefall"}, 32'(done), 0);
    chk({tag, "_hold"}, 32'(bin_out), 32'(exp));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    bcd_in = 12'h000;

    // Reset, then idle
    tick();
    tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_bin", 32'(bin_out), 0);
    chk("rst_err", 32'(err), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_busy", 32'(busy), 0);
      chk("idle_done", 32'(done), 0);
      chk("idle_bin", 32'(bin_out), 0);
      chk("idle_err", 32'(err), 0);
    end

    // Main function and boundaries
    convert(12'h255, 255, "c255");
    convert(12'h000, 0, "c000");
    convert(12'h999, 999, "c999");
    convert(12'h308, 308, "c308");

    // Invalid digit: error completion next cycle, no busy
    start  = 1'b1;
    bcd_in = 12'h1A5;
    tick();
    start  = 1'b0;
    chk("inv_done", 32'(done), 1);
    chk("inv_err", 32'(err), 1);
    chk("inv_bin", 32'(bin_out), 0);
    chk("inv_busy", 32'(busy), 0);
    tick();
    chk("inv_donefall", 32'(done), 0);
    chk("inv_errhold", 32'(err), 1);
    chk("inv_busy2", 32'(busy), 0);
    convert(12'h042, 42, "c042");

    // Start held through a conversion with bcd_in changing
    start  = 1'b1;
    bcd_in = 12'h128;
    tick();
    bcd_in = 12'h777;
    for (int i = 1; i < 12; i++) begin
      tick();
      chk("hold_busy", 32'(busy), 1);
      chk("hold_nodone", 32'(done), 0);
    end
    tick();
    chk("hold_done", 32'(done), 1);
    chk("hold_bin", 32'(bin_out), 128);
    // start still high in the done cycle: accepted at the next edge
    tick();
    start = 1'b0;
    chk("b2b_busy", 32'(busy), 1);
    chk("b2b_nodone", 32'(done), 0);
    for (int i = 2; i < 13; i++) begin
      tick();
      chk("b2b_nodone", 32'(done), 0);
    end
    tick();
    chk("b2b_done", 32'(done), 1);
    chk("b2b_bin", 32'(bin_out), 777);

    // Reset mid-conversion aborts with no done
    tick();
    start  = 1'b1;
    bcd_in = 12'h500;
    tick();
    start  = 1'b0;
    for (int i = 1; i < 6; i++) tick();
    chk("abort_busy_pre", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_bin", 32'(bin_out), 0);
    chk("abort_err", 32'(err), 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("abort_nodone", 32'(done), 0);
      chk("abort_idle", 32'(busy), 0);
    end
    convert(12'h500, 500, "c500");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
